// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit, the ALU and the datapath.
package control_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned STATE_W  = 3;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] ASRC_RS1  = 2'b00;
  localparam logic [1:0] ASRC_PC   = 2'b01;
  localparam logic [1:0] ASRC_ZERO = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [3:0] {
    CL_R, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BAD
  } iclass_t;

  // ALU-side control payload presented to the datapath
  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          a_src;
    logic                b_src;
    logic [2:0]          imm_src;
  } alu_ctrl_t;

  function automatic iclass_t opcode_class(input logic [6:0] op);
    case (op)
      OP_R:      return CL_R;
      OP_IALU:   return CL_IALU;
      OP_LOAD:   return CL_LOAD;
      OP_STORE:  return CL_STORE;
      OP_BRANCH: return CL_BRANCH;
      OP_LUI:    return CL_LUI;
      OP_AUIPC:  return CL_AUIPC;
      OP_JAL:    return CL_JAL;
      OP_JALR:   return CL_JALR;
      default:   return CL_BAD;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps instruction class and function fields to an ALU operation and an illegal flag.
module alu_op_decoder
  import control_pkg::*;
(
  input  iclass_t             cls,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                imm30,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal
);

  // funct3 selects the base op; bit 30 turns add into sub (R only) and srl into sra
  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (cls)
      CL_R: begin
        alu_op = {1'b0, funct3};
        if (funct7[5]) begin
          if (funct3 == 3'b000)      alu_op  = ALU_SUB;
          else if (funct3 == 3'b101) alu_op  = ALU_SRA;
          else                       illegal = 1'b1;
        end
        if (funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
      end
      CL_IALU: alu_op = (funct3 == 3'b101 && imm30) ? ALU_SRA : {1'b0, funct3};
      CL_BAD:  illegal = 1'b1;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: fetch, decode, execute, memory, writeback.
module multicycle_control
  import control_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                mem_ready,
  input  logic                br_taken,
  output logic                ir_we,
  output logic [ALU_OP_W-1:0] ALUOp,
  output logic [1:0]          ALUASrc,
  output logic                ALUBSrc,
  output logic [2:0]          ImmSrc,
  output logic                RUWr,
  output logic [1:0]          RUDataWrSrc,
  output logic                DMRd,
  output logic                DMWr,
  output logic                pc_we,
  output logic                pc_src,
  output logic                illegal,
  output logic [STATE_W-1:0]  state
);

  state_t              cur, nxt;
  logic [6:0]          opcode_q, funct7_q;
  logic [2:0]          funct3_q;
  logic                imm30_q;
  logic                illegal_q;
  iclass_t             cls;
  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_illegal;
  alu_ctrl_t           ctrl;
  logic                unused_instr_bits;

  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};
  assign cls     = opcode_class(opcode_q);
  assign state   = cur;
  assign illegal = illegal_q;

  alu_op_decoder u_alu_op_decoder (
    .cls     (cls),
    .funct3  (funct3_q),
    .funct7  (funct7_q),
    .imm30   (imm30_q),
    .alu_op  (dec_op),
    .illegal (dec_illegal)
  );

  // State register and sticky illegal flag
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Capture the instruction fields only when the word is accepted in FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= '0;
      funct3_q <= '0;
      funct7_q <= '0;
      imm30_q  <= 1'b0;
    end else if (cur == S_FETCH && instr_valid) begin
      opcode_q <= instr[6:0];
      funct3_q <= instr[14:12];
      funct7_q <= instr[31:25];
      imm30_q  <= instr[30];
    end
  end

  // Operand selects and immediate format for the latched class
  always_comb begin
    ctrl.alu_op  = dec_op;
    ctrl.a_src   = ASRC_RS1;
    ctrl.b_src   = 1'b1;
    ctrl.imm_src = IMM_I;
    case (cls)
      CL_R:      ctrl.b_src = 1'b0;
      CL_STORE:  ctrl.imm_src = IMM_S;
      CL_BRANCH: begin ctrl.a_src = ASRC_PC;   ctrl.imm_src = IMM_B; end
      CL_LUI:    begin ctrl.a_src = ASRC_ZERO; ctrl.imm_src = IMM_U; end
      CL_AUIPC:  begin ctrl.a_src = ASRC_PC;   ctrl.imm_src = IMM_U; end
      CL_JAL:    begin ctrl.a_src = ASRC_PC;   ctrl.imm_src = IMM_J; end
      default:   ctrl.imm_src = IMM_I;
    endcase
  end

  // Next state and strobes; reset forces every output to its idle value
  always_comb begin
    nxt         = cur;
    ir_we       = 1'b0;
    ALUOp       = ALU_ADD;
    ALUASrc     = ASRC_RS1;
    ALUBSrc     = 1'b0;
    ImmSrc      = IMM_I;
    RUWr        = 1'b0;
    RUDataWrSrc = WB_ALU;
    DMRd        = 1'b0;
    DMWr        = 1'b0;
    pc_we       = 1'b0;
    pc_src      = 1'b0;

    if (cur inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      ALUOp   = ctrl.alu_op;
      ALUASrc = ctrl.a_src;
      ALUBSrc = ctrl.b_src;
      ImmSrc  = ctrl.imm_src;
    end

    case (cur)
      S_FETCH: begin
        ir_we = instr_valid;
        if (instr_valid) nxt = S_DECODE;
      end
      S_DECODE: nxt = dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (cls == CL_LOAD || cls == CL_STORE) begin
          nxt = S_MEM;
        end else if (cls == CL_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = br_taken;
          nxt    = S_FETCH;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        DMRd = (cls == CL_LOAD);
        DMWr = (cls == CL_STORE);
        if (mem_ready) begin
          if (cls == CL_LOAD) begin
            nxt = S_WB;
          end else begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end
        end
      end
      S_WB: begin
        RUWr   = 1'b1;
        pc_we  = 1'b1;
        pc_src = (cls == CL_JAL || cls == CL_JALR);
        if (cls == CL_LOAD)                        RUDataWrSrc = WB_MEM;
        else if (cls == CL_JAL || cls == CL_JALR)  RUDataWrSrc = WB_PC4;
        else                                       RUDataWrSrc = WB_ALU;
        nxt = S_FETCH;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_FETCH;
    endcase

    if (rst) begin
      ir_we       = 1'b0;
      ALUOp       = ALU_ADD;
      ALUASrc     = ASRC_RS1;
      ALUBSrc     = 1'b0;
      ImmSrc      = IMM_I;
      RUWr        = 1'b0;
      RUDataWrSrc = WB_ALU;
      DMRd        = 1'b0;
      DMWr        = 1'b0;
      pc_we       = 1'b0;
      pc_src      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst, instr_valid, mem_ready, br_taken;
  logic [31:0] instr;
  logic        ir_we, ALUBSrc, RUWr, DMRd, DMWr, pc_we, pc_src, illegal;
  logic [3:0]  ALUOp;
  logic [1:0]  ALUASrc, RUDataWrSrc;
  logic [2:0]  ImmSrc, state;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .mem_ready(mem_ready), .br_taken(br_taken), .ir_we(ir_we),
    .ALUOp(ALUOp), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ImmSrc(ImmSrc),
    .RUWr(RUWr), .RUDataWrSrc(RUDataWrSrc), .DMRd(DMRd), .DMWr(DMWr),
    .pc_we(pc_we), .pc_src(pc_src), .illegal(illegal), .state(state)
  );

  // Per-instruction observation / expectation record
  typedef struct {
    int n_fetch, n_dec, n_exec, n_mem, n_wb, n_other;
    int n_irwe, n_dmrd, n_dmwr, n_ruwr;
    int alu, asrc, bsrc, imm, rusrc, pcsrc;
  } rec_t;

  rec_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic rec_t blank();
    rec_t r;
    r = '{default: 0};
    return r;
  endfunction

  // Reference model: expected per-instruction behaviour from the ISA rules
  function automatic rec_t model(input logic [31:0] w, input int v, input int m, input bit bt);
    rec_t e;
    logic [6:0] op;
    int f3;
    bit b30;
    e = blank();
    op  = w[6:0];
    f3  = int'(w[14:12]);
    b30 = w[30];
    e.n_fetch = v + 1; e.n_dec = 1; e.n_exec = 1; e.n_irwe = 1;
    e.bsrc = 1;
    case (op)
      7'h33: begin
        e.alu = f3; e.bsrc = 0;
        if (b30 && f3 == 0) e.alu = 8;
        if (b30 && f3 == 5) e.alu = 13;
        e.n_wb = 1;
      end
      7'h13: begin
        e.alu = f3;
        if (b30 && f3 == 5) e.alu = 13;
        e.n_wb = 1;
      end
      7'h03: begin e.n_mem = m + 1; e.n_dmrd = m + 1; e.n_wb = 1; e.rusrc = 1; end
      7'h23: begin e.n_mem = m + 1; e.n_dmwr = m + 1; e.imm = 1; end
      7'h63: begin e.asrc = 1; e.imm = 2; e.pcsrc = int'(bt); end
      7'h37: begin e.asrc = 2; e.imm = 3; e.n_wb = 1; end
      7'h17: begin e.asrc = 1; e.imm = 3; e.n_wb = 1; end
      7'h6F: begin e.asrc = 1; e.imm = 4; e.n_wb = 1; e.pcsrc = 1; e.rusrc = 2; end
      7'h67: begin e.n_wb = 1; e.pcsrc = 1; e.rusrc = 2; end
      default: e.n_other = 1;
    endcase
    e.n_ruwr = e.n_wb;
    return e;
  endfunction

  // Random legal instruction of a random class
  function automatic logic [31:0] gen_word();
    logic [31:0] r;
    logic [6:0]  ops [9];
    logic [6:0]  f7;
    logic [2:0]  f3;
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    r = $urandom;
    k = $urandom_range(0, 8);
    if (k == 0) begin
      if ($urandom_range(0, 1) == 1) begin
        f7 = 7'h20;
        f3 = ($urandom_range(0, 1) == 1) ? 3'd5 : 3'd0;
      end else begin
        f7 = 7'h00;
        f3 = r[14:12];
      end
      return {f7, r[24:15], f3, r[11:7], ops[0]};
    end
    return {r[31:7], ops[k]};
  endfunction

  // Drive one instruction open-loop along the reference timeline
  task automatic run_instr(input logic [31:0] w, input int v, input int m, input bit bt);
    rec_t e;
    int   ncyc, mem_start;
    e = model(w, v, m, bt);
    sb.push_back(e);
    ncyc      = e.n_fetch + e.n_dec + e.n_exec + e.n_mem + e.n_wb;
    mem_start = v + 3;
    for (int t = 0; t < ncyc; t++) begin
      if (t <= v) begin
        instr_valid = (t == v);
        instr       = (t == v) ? w : $urandom;
      end else begin
        instr_valid = 1'($urandom_range(0, 1));
        instr       = $urandom;
      end
      br_taken = (t == v + 2) ? bt : 1'($urandom_range(0, 1));
      if (t >= mem_start && t < mem_start + m) mem_ready = 1'b0;
      else if (t == mem_start + m)             mem_ready = 1'b1;
      else                                     mem_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: accumulate observations, compare against the scoreboard on each retire
  rec_t acc = '{default: 0};
  always @(negedge clk) begin
    rec_t e;
    if (!mon_en) begin
      acc = blank();
    end else begin
      case (state)
        3'd0: acc.n_fetch++;
        3'd1: acc.n_dec++;
        3'd2: acc.n_exec++;
        3'd3: acc.n_mem++;
        3'd4: acc.n_wb++;
        default: acc.n_other++;
      endcase
      if (ir_we) acc.n_irwe++;
      if (DMRd)  acc.n_dmrd++;
      if (DMWr)  acc.n_dmwr++;
      if (RUWr) begin
        acc.n_ruwr++;
        acc.rusrc = int'(RUDataWrSrc);
      end
      if (state == 3'd2) begin
        acc.alu  = int'(ALUOp);
        acc.asrc = int'(ALUASrc);
        acc.bsrc = int'(ALUBSrc);
        acc.imm  = int'(ImmSrc);
      end
      if (pc_we) begin
        acc.pcsrc = int'(pc_src);
        if (sb.size() == 0) begin
          chk("spurious_retire", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("fetch_cycles", acc.n_fetch, e.n_fetch);
          chk("decode_cycles", acc.n_dec, e.n_dec);
          chk("exec_cycles", acc.n_exec, e.n_exec);
          chk("mem_cycles", acc.n_mem, e.n_mem);
          chk("wb_cycles", acc.n_wb, e.n_wb);
          chk("other_states", acc.n_other, e.n_other);
          chk("ir_we_count", acc.n_irwe, e.n_irwe);
          chk("dmrd_count", acc.n_dmrd, e.n_dmrd);
          chk("dmwr_count", acc.n_dmwr, e.n_dmwr);
          chk("ruwr_count", acc.n_ruwr, e.n_ruwr);
          chk("aluop", acc.alu, e.alu);
          chk("alu_a_src", acc.asrc, e.asrc);
          chk("alu_b_src", acc.bsrc, e.bsrc);
          chk("imm_src", acc.imm, e.imm);
          chk("ru_data_src", acc.rusrc, e.rusrc);
          chk("pc_src", acc.pcsrc, e.pcsrc);
          chk("illegal_clear", int'(illegal), 0);
        end
        acc = blank();
      end
    end
  end

  logic [31:0] bad_words [4];

  initial begin
    bad_words = '{32'hFFFFFFFF, 32'h022081B3, 32'h4020C1B3, 32'h00000000};
    rst = 1'b1; instr_valid = 1'b0; instr = '0; mem_ready = 1'b0; br_taken = 1'b0;

    // Outputs forced idle while reset is held, even with inputs active
    @(posedge clk); #1;
    instr_valid = 1'b1; mem_ready = 1'b1; br_taken = 1'b1; instr = 32'h002081B3;
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_ir_we", int'(ir_we), 0);
    chk("rst_strobes", int'(RUWr) + int'(DMRd) + int'(DMWr) + int'(pc_we), 0);
    chk("rst_selects", int'(ALUOp) + int'(ALUASrc) + int'(ALUBSrc) + int'(ImmSrc) + int'(RUDataWrSrc) + int'(pc_src), 0);
    chk("rst_illegal", int'(illegal), 0);
    @(posedge clk); #1;
    rst = 1'b0; instr_valid = 1'b0;
    mon_en = 1'b1;

    run_instr(32'h002081B3, 0, 0, 1'b0); // add
    run_instr(32'h402081B3, 0, 0, 1'b0); // sub
    run_instr(32'h4030D093, 0, 0, 1'b0); // srai
    run_instr(32'h0020B1B3, 0, 0, 1'b0); // sltu
    run_instr(32'h0080A283, 0, 2, 1'b0); // lw, 2 wait cycles
    run_instr(32'h00208463, 0, 0, 1'b1); // beq taken
    run_instr(32'h00208463, 0, 0, 1'b0); // beq not taken
    run_instr(32'h0050A223, 0, 1, 1'b0); // sw
    run_instr(32'h123450B7, 1, 0, 1'b0); // lui
    run_instr(32'h00000097, 0, 0, 1'b0); // auipc
    run_instr(32'h008000EF, 2, 0, 1'b0); // jal
    run_instr(32'h000080E7, 0, 0, 1'b0); // jalr
    run_instr(32'h002081B3, 3, 0, 1'b0); // add with fetch stalls

    for (int n = 0; n < 200; n++)
      run_instr(gen_word(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    @(posedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    mon_en = 1'b0;

    // Illegal words trap, stay silent, and clear only on reset
    foreach (bad_words[i]) begin
      do_reset();
      instr = bad_words[i]; instr_valid = 1'b1; mem_ready = 1'b1; br_taken = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0; instr = $urandom;
      @(posedge clk); #1;
      for (int c = 0; c < 12; c++) begin
        instr_valid = 1'($urandom_range(0, 1));
        mem_ready   = 1'($urandom_range(0, 1));
        #1;
        chk($sformatf("trap%0d_state", i), int'(state), 7);
        chk($sformatf("trap%0d_illegal", i), int'(illegal), 1);
        chk($sformatf("trap%0d_strobes", i),
            int'(ir_we) + int'(RUWr) + int'(DMRd) + int'(DMWr) + int'(pc_we), 0);
        @(posedge clk); #1;
      end
      instr_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk($sformatf("trap%0d_rst_state", i), int'(state), 0);
      chk($sformatf("trap%0d_rst_illegal", i), int'(illegal), 0);
    end

    // Reset while a store is waiting in MEM abandons it
    do_reset();
    instr = 32'h0050A223; instr_valid = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sw_mem_state", int'(state), 3);
    chk("sw_dmwr_before_rst", int'(DMWr), 1);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    chk("sw_dmwr_in_rst", int'(DMWr), 0);
    chk("sw_pc_we_in_rst", int'(pc_we), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("sw_after_rst_state", int'(state), 0);
      chk("sw_after_rst_strobes", int'(DMWr) + int'(pc_we) + int'(RUWr) + int'(DMRd), 0);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
